fir_sample_sequencer: RTL and testbench



---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_hist_ram.sv | 33 +++
 rtl/fir_sample_sequencer.sv | 174 +++++++++++++++++
 tb/tb_fir_sample_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants for the FIR sample sequencer and the MAC core it feeds.
package fir_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_TAPS   = 4;
  localparam int unsigned DEF_IDX_W  = (DEF_TAPS > 1) ? $clog2(DEF_TAPS) : 1;

  // Q1.7 sample format: 0x20 represents 0.25
  localparam int unsigned FRAC_BITS  = 7;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

endpackage

// File: rtl/fir_hist_ram.sv
// TAPS-deep sample history: synchronous write, combinational read, one-cycle zero-fill.
module fir_hist_ram
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned TAPS   = DEF_TAPS,
  parameter int unsigned IDX_W  = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [TAPS];

  always_ff @(posedge clk) begin
    if (!i_rst_n || i_clr) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fir_sample_sequencer.sv
// Accepts samples and replays the last TAPS of them, newest first, as (sample, k) pairs to the MAC.
module fir_sample_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned TAPS   = DEF_TAPS,
  parameter int unsigned IDX_W  = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              global_reset_n,
  input  logic [DATA_W-1:0] xn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              hist_clr,
  output logic [DATA_W-1:0] mac_sample,
  output logic [IDX_W-1:0]  mac_coef_idx,
  output logic              mac_first,
  output logic              mac_last,
  output logic              mac_valid,
  input  logic              mac_ready
);

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(TAPS - 1);

  logic [0:0]        r_state;
  logic [IDX_W-1:0]  r_wr_ptr;
  logic [IDX_W-1:0]  r_rd_ptr;
  logic [IDX_W-1:0]  r_k;
  logic              r_in_ready;
  logic              r_mac_valid;
  logic              r_mac_first;
  logic              r_mac_last;
  logic [DATA_W-1:0] r_mac_sample;
  logic [IDX_W-1:0]  r_mac_coef_idx;

  logic [0:0]        w_state_nxt;
  logic [IDX_W-1:0]  w_wr_ptr_nxt;
  logic [IDX_W-1:0]  w_rd_ptr_nxt;
  logic [IDX_W-1:0]  w_k_nxt;
  logic              w_in_ready_nxt;
  logic              w_mac_valid_nxt;
  logic              w_mac_first_nxt;
  logic              w_mac_last_nxt;
  logic [DATA_W-1:0] w_mac_sample_nxt;
  logic [IDX_W-1:0]  w_mac_coef_idx_nxt;

  logic              w_idle;
  logic              w_accept;
  logic              w_clr;
  logic              w_hs;
  logic [IDX_W-1:0]  w_rd_dec;
  logic [IDX_W-1:0]  w_k_inc;
  logic [DATA_W-1:0] w_rdata;

  // Clear takes priority over a simultaneous sample by dropping in_ready that cycle
  assign in_ready = r_in_ready & ~hist_clr;
  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle & in_valid & in_ready;
  assign w_clr    = w_idle & hist_clr;
  assign w_hs     = r_mac_valid & mac_ready;
  assign w_rd_dec = (r_rd_ptr == '0) ? K_LAST : r_rd_ptr - IDX_W'(1);
  assign w_k_inc  = r_k + IDX_W'(1);

  fir_hist_ram #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS),
    .IDX_W  (IDX_W)
  ) u_hist (
    .clk     (clk),
    .i_rst_n (global_reset_n),
    .i_clr   (w_clr),
    .i_we    (w_accept),
    .i_waddr (r_wr_ptr),
    .i_wdata (xn),
    .i_raddr (w_rd_dec),
    .o_rdata (w_rdata)
  );

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt        = r_state;
    w_wr_ptr_nxt       = r_wr_ptr;
    w_rd_ptr_nxt       = r_rd_ptr;
    w_k_nxt            = r_k;
    w_in_ready_nxt     = r_in_ready;
    w_mac_valid_nxt    = r_mac_valid;
    w_mac_first_nxt    = r_mac_first;
    w_mac_last_nxt     = r_mac_last;
    w_mac_sample_nxt   = r_mac_sample;
    w_mac_coef_idx_nxt = r_mac_coef_idx;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          // k=0 pair bypasses the history write that lands on the same edge
          w_state_nxt        = ST_ISSUE;
          w_rd_ptr_nxt       = r_wr_ptr;
          w_k_nxt            = '0;
          w_in_ready_nxt     = 1'b0;
          w_mac_valid_nxt    = 1'b1;
          w_mac_first_nxt    = 1'b1;
          w_mac_last_nxt     = (K_LAST == '0);
          w_mac_sample_nxt   = xn;
          w_mac_coef_idx_nxt = '0;
        end else if (w_clr) begin
          w_wr_ptr_nxt = '0;
        end
      end

      ST_ISSUE: begin
        if (w_hs) begin
          if (r_k == K_LAST) begin
            w_state_nxt        = ST_IDLE;
            w_wr_ptr_nxt       = (r_wr_ptr == K_LAST) ? '0 : r_wr_ptr + IDX_W'(1);
            w_k_nxt            = '0;
            w_in_ready_nxt     = 1'b1;
            w_mac_valid_nxt    = 1'b0;
            w_mac_first_nxt    = 1'b0;
            w_mac_last_nxt     = 1'b0;
            w_mac_sample_nxt   = '0;
            w_mac_coef_idx_nxt = '0;
          end else begin
            w_rd_ptr_nxt       = w_rd_dec;
            w_k_nxt            = w_k_inc;
            w_mac_first_nxt    = 1'b0;
            w_mac_last_nxt     = (w_k_inc == K_LAST);
            w_mac_sample_nxt   = w_rdata;
            w_mac_coef_idx_nxt = w_k_inc;
          end
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_in_ready_nxt  = 1'b1;
        w_mac_valid_nxt = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers
  always_ff @(posedge clk) begin
    if (!global_reset_n) begin
      r_state        <= ST_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_k            <= '0;
      r_in_ready     <= 1'b1;
      r_mac_valid    <= 1'b0;
      r_mac_first    <= 1'b0;
      r_mac_last     <= 1'b0;
      r_mac_sample   <= '0;
      r_mac_coef_idx <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_k            <= w_k_nxt;
      r_in_ready     <= w_in_ready_nxt;
      r_mac_valid    <= w_mac_valid_nxt;
      r_mac_first    <= w_mac_first_nxt;
      r_mac_last     <= w_mac_last_nxt;
      r_mac_sample   <= w_mac_sample_nxt;
      r_mac_coef_idx <= w_mac_coef_idx_nxt;
    end
  end

  assign mac_valid    = r_mac_valid;
  assign mac_first    = r_mac_first;
  assign mac_last     = r_mac_last;
  assign mac_sample   = r_mac_sample;
  assign mac_coef_idx = r_mac_coef_idx;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Bench for fir_sample_sequencer: directed plan scenarios plus randomized traffic against a history model.
module tb_fir_sample_sequencer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TAPS   = 4;
  localparam int unsigned IDX_W  = 2;

  logic              clk = 1'b0;
  logic              global_reset_n;
  logic [DATA_W-1:0] xn;
  logic              in_valid;
  logic              in_ready;
  logic              hist_clr;
  logic [DATA_W-1:0] mac_sample;
  logic [IDX_W-1:0]  mac_coef_idx;
  logic              mac_first;
  logic              mac_last;
  logic              mac_valid;
  logic              mac_ready;

  int vectors     = 0;
  int miscompares = 0;

  // model[j] is x[n-j] for the most recently accepted sample
  logic [DATA_W-1:0] model [TAPS];

  always #5 clk = ~clk;

  fir_sample_sequencer #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS),
    .IDX_W  (IDX_W)
  ) dut (
    .clk            (clk),
    .global_reset_n (global_reset_n),
    .xn             (xn),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .hist_clr       (hist_clr),
    .mac_sample     (mac_sample),
    .mac_coef_idx   (mac_coef_idx),
    .mac_first      (mac_first),
    .mac_last       (mac_last),
    .mac_valid      (mac_valid),
    .mac_ready      (mac_ready)
  );

  task automatic model_clear();
    for (int i = 0; i < int'(TAPS); i++) model[i] = '0;
  endtask

  task automatic model_push(input logic [DATA_W-1:0] x);
    for (int i = int'(TAPS) - 1; i > 0; i--) model[i] = model[i-1];
    model[0] = x;
  endtask

  // Sends one sample and follows its burst; starts and ends at a falling edge.
  task automatic send(input logic [DATA_W-1:0] x, input int stall_k, input int stall_len,
                      input int stall_pct, input bit noise);
    logic [DATA_W-1:0] exp [TAPS];
    int  k, stalls, cyc;
    bit  acc, rdy;
    in_valid = 1'b1; xn = x; hist_clr = 1'b0; mac_ready = 1'b0;
    acc = 1'b0;
    for (int c = 0; c < 20 && !acc; c++) begin
      #1;
      if (in_ready === 1'b1) acc = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL accept x=%h: in_ready stayed %b, required 1", x, in_ready);
      in_valid = 1'b0;
      return;
    end
    model_push(x);
    for (int i = 0; i < int'(TAPS); i++) exp[i] = model[i];
    k = 0; stalls = 0; cyc = 0;
    while (k < int'(TAPS) && cyc < 100) begin
      if (k == stall_k && stalls < stall_len) begin
        rdy = 1'b0; stalls++;
      end else begin
        rdy = ($urandom_range(0, 99) >= stall_pct);
      end
      mac_ready = rdy;
      in_valid  = noise;
      hist_clr  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      xn        = noise ? DATA_W'($urandom) : x;
      #1;
      vectors++;
      if (mac_valid !== 1'b1 || mac_sample !== exp[k] || mac_coef_idx !== IDX_W'(k) ||
          mac_first !== (k == 0) || mac_last !== (k == int'(TAPS) - 1) || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL burst x=%h k=%0d: got v=%b s=%h idx=%0d f=%b l=%b in_rdy=%b, required v=1 s=%h idx=%0d f=%b l=%b in_rdy=0",
                 x, k, mac_valid, mac_sample, mac_coef_idx, mac_first, mac_last, in_ready,
                 exp[k], k, (k == 0), (k == int'(TAPS) - 1));
      end
      if (rdy) k++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0; hist_clr = 1'b0; mac_ready = 1'b0; xn = '0;
    #1;
    vectors++;
    if (mac_valid !== 1'b0 || in_ready !== 1'b1 || mac_last !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_burst x=%h: got v=%b in_rdy=%b l=%b, required 0 1 0",
               x, mac_valid, in_ready, mac_last);
    end
    if (stall_pct == 0 && stall_len == 0) begin
      vectors++;
      if (cyc != int'(TAPS)) begin
        miscompares++;
        $display("FAIL burst_len x=%h: got %0d cycles, required %0d", x, cyc, TAPS);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    global_reset_n = 1'b0; in_valid = 1'b1; xn = 8'h5A; hist_clr = 1'b0; mac_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1 || mac_valid !== 1'b0 || mac_first !== 1'b0 || mac_last !== 1'b0 ||
        mac_sample !== '0 || mac_coef_idx !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b v=%b f=%b l=%b s=%h idx=%0d, required 1 0 0 0 00 0",
               in_ready, mac_valid, mac_first, mac_last, mac_sample, mac_coef_idx);
    end
    in_valid = 1'b0; mac_ready = 1'b0;
    @(negedge clk);
    global_reset_n = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_directed();
    send(8'h20, -1, 0, 0, 1'b0);
    send(8'h10, -1, 0, 0, 1'b0);
    send(8'h08, -1, 0, 0, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 6; i++) send(DATA_W'(i), -1, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    send(8'hC3, 1, 3, 0, 1'b1);
    send(8'h3C, 2, 2, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; xn = 8'h33; hist_clr = 1'b0; mac_ready = 1'b0;
    #1;
    @(negedge clk);
    model_push(8'h33);
    in_valid = 1'b0; mac_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (mac_valid !== 1'b1 || mac_coef_idx !== IDX_W'(2)) begin
      miscompares++;
      $display("FAIL pre_reset_k2: got v=%b idx=%0d, required 1 2", mac_valid, mac_coef_idx);
    end
    global_reset_n = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (mac_valid !== 1'b0 || in_ready !== 1'b1 || mac_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_burst: got v=%b rdy=%b l=%b, required 0 1 0", mac_valid, in_ready, mac_last);
    end
    global_reset_n = 1'b1; mac_ready = 1'b0;
    model_clear();
    @(negedge clk);
    #1;
    vectors++;
    if (mac_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_quiet: got v=%b, required 0", mac_valid);
    end
    @(negedge clk);
    send(8'h7F, -1, 0, 0, 1'b0);
  endtask

  task automatic test_clear();
    for (int i = 0; i < int'(TAPS); i++) send(DATA_W'($urandom_range(1, 255)), -1, 0, 0, 1'b0);
    in_valid = 1'b1; hist_clr = 1'b1; xn = 8'h55;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_blocks_ready: got in_ready=%b, required 0", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; hist_clr = 1'b0;
    #1;
    vectors++;
    if (mac_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_no_accept: got v=%b rdy=%b, required 0 1", mac_valid, in_ready);
    end
    model_clear();
    @(negedge clk);
    send(8'h80, -1, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        hist_clr = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        hist_clr = 1'b0;
        model_clear();
      end
      send(DATA_W'($urandom), -1, 0, 40, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    global_reset_n = 1'b0; xn = '0; in_valid = 1'b0; hist_clr = 1'b0; mac_ready = 1'b0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_directed();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
